// File: rtl/id_ex_stage_pkg.sv
// id_ex_stage_pkg: ALU op codes and stage constants shared by the ID/EX
// register, its forwarding muxes and anything that decodes ALUctr.
package id_ex_stage_pkg;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'b0000,
    ALU_ADDU = 4'b0001,
    ALU_SUB  = 4'b0010,
    ALU_SUBU = 4'b0011,
    ALU_AND  = 4'b0100,
    ALU_OR   = 4'b0101,
    ALU_XOR  = 4'b0110,
    ALU_NOR  = 4'b0111,
    ALU_SLT  = 4'b1010,
    ALU_SLTU = 4'b1011
  } alu_op_e;

  // A bubble runs addu on zero operands: harmless, never writes back.
  localparam alu_op_e ALU_NOP = ALU_ADDU;

  // Register 0 is hard-wired to zero and must never be a forwarding target.
  localparam int REG_ZERO = 0;

  // Width of the instruction immediate field.
  localparam int IMM_W = 16;

endpackage

// File: rtl/id_ex_stage_if.sv
// id_ex_stage_if: ID-side inputs, MEM/WB forwarding sources and the EX-side
// outputs of the ID/EX register. master = upstream pipeline, slave = stage.
interface id_ex_stage_if #(
  parameter int DW = 32,
  parameter int RW = 5
);
  // pipeline control
  logic          stall;
  logic          flush;

  // decoded instruction from ID
  logic          id_valid;
  logic [DW-1:0] id_rs_data;
  logic [DW-1:0] id_rt_data;
  logic [RW-1:0] id_rs;
  logic [RW-1:0] id_rt;
  logic [RW-1:0] id_dst;
  logic [15:0]   id_imm16;
  logic          id_ext_op;
  logic          id_alu_src;
  logic [3:0]    id_alu_ctr;
  logic          id_reg_write;

  // forwarding sources
  logic          mem_reg_write;
  logic          wb_reg_write;
  logic [RW-1:0] mem_dst;
  logic [RW-1:0] wb_dst;
  logic [DW-1:0] mem_result;
  logic [DW-1:0] wb_result;

  // to the ALU and EX/MEM
  logic [DW-1:0] ex_a;
  logic [DW-1:0] ex_b;
  logic [3:0]    ex_alu_ctr;
  logic [DW-1:0] ex_store_data;
  logic [RW-1:0] ex_dst;
  logic          ex_reg_write;
  logic          ex_valid;

  modport master (
    output stall, flush,
    output id_valid, id_rs_data, id_rt_data, id_rs, id_rt, id_dst,
    output id_imm16, id_ext_op, id_alu_src, id_alu_ctr, id_reg_write,
    output mem_reg_write, wb_reg_write, mem_dst, wb_dst, mem_result, wb_result,
    input  ex_a, ex_b, ex_alu_ctr, ex_store_data, ex_dst, ex_reg_write, ex_valid
  );

  modport slave (
    input  stall, flush,
    input  id_valid, id_rs_data, id_rt_data, id_rs, id_rt, id_dst,
    input  id_imm16, id_ext_op, id_alu_src, id_alu_ctr, id_reg_write,
    input  mem_reg_write, wb_reg_write, mem_dst, wb_dst, mem_result, wb_result,
    output ex_a, ex_b, ex_alu_ctr, ex_store_data, ex_dst, ex_reg_write, ex_valid
  );
endinterface

// File: rtl/id_ex_stage_fwd_mux.sv
// fwd_mux: picks one source operand from MEM, WB or the latched register
// data. MEM is younger than WB so it wins; register 0 never forwards.
// Forwarding exists only when ID_EX_FORWARD_EN is defined; otherwise the
// latched data passes straight through and the MEM/WB inputs are ignored.
module fwd_mux
  import id_ex_stage_pkg::*;
#(
  parameter int DW = 32,
  parameter int RW = 5
) (
  input  logic [RW-1:0] src_reg,
  input  logic [DW-1:0] reg_data,
  input  logic          mem_we,
  input  logic [RW-1:0] mem_dst,
  input  logic [DW-1:0] mem_data,
  input  logic          wb_we,
  input  logic [RW-1:0] wb_dst,
  input  logic [DW-1:0] wb_data,
  output logic [DW-1:0] fwd_data
);

`ifdef ID_EX_FORWARD_EN
  logic src_nz;
  logic mem_hit;
  logic wb_hit;

  // MEM first, then WB, else the value read in ID
  always_comb begin
    src_nz   = (src_reg != RW'(REG_ZERO));
    mem_hit  = mem_we && (mem_dst == src_reg) && src_nz;
    wb_hit   = wb_we  && (wb_dst  == src_reg) && src_nz;
    fwd_data = reg_data;
    if (mem_hit)     fwd_data = mem_data;
    else if (wb_hit) fwd_data = wb_data;
  end
`else
  logic unused_fwd;
  assign unused_fwd = ^{src_reg, mem_we, mem_dst, mem_data, wb_we, wb_dst, wb_data};

  // no forwarding: upstream stalls resolve hazards, operand is the latched data
  always_comb begin
    fwd_data = reg_data;
  end
`endif

endmodule

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register feeding the 32-bit ALU.
// Latches decoded operands/control, sign/zero-extends the immediate at
// latch time, forwards MEM/WB results onto A, B and store data, and passes
// destination/write-enable on to EX/MEM. Edge priority: rst > flush > stall
// > load. Build option: ID_EX_FORWARD_EN enables MEM/WB forwarding.
module id_ex_stage
  import id_ex_stage_pkg::*;
#(
  parameter int DW = 32,
  parameter int RW = 5
) (
  input  logic          clk,
  input  logic          rst,
  id_ex_stage_if.slave  bus
);

  typedef struct packed {
    logic          valid;
    logic [DW-1:0] rs_data;
    logic [DW-1:0] rt_data;
    logic [RW-1:0] rs;
    logic [RW-1:0] rt;
    logic [RW-1:0] dst;
    logic [DW-1:0] ext_imm;
    logic          alu_src;
    logic [3:0]    alu_ctr;
    logic          reg_write;
  } stage_t;

  // Bubble: nothing valid, no write, addu on zeros, no register numbers.
  function automatic stage_t bubble();
    stage_t s;
    s         = '0;
    s.alu_ctr = ALU_NOP;
    return s;
  endfunction

  stage_t        stage_d, stage_q;
  logic [DW-1:0] rs_fwd;
  logic [DW-1:0] rt_fwd;
  logic [DW-1:0] id_ext_imm;

  fwd_mux #(.DW(DW), .RW(RW)) u_fwd_rs (
    .src_reg  (stage_q.rs),
    .reg_data (stage_q.rs_data),
    .mem_we   (bus.mem_reg_write),
    .mem_dst  (bus.mem_dst),
    .mem_data (bus.mem_result),
    .wb_we    (bus.wb_reg_write),
    .wb_dst   (bus.wb_dst),
    .wb_data  (bus.wb_result),
    .fwd_data (rs_fwd)
  );

  fwd_mux #(.DW(DW), .RW(RW)) u_fwd_rt (
    .src_reg  (stage_q.rt),
    .reg_data (stage_q.rt_data),
    .mem_we   (bus.mem_reg_write),
    .mem_dst  (bus.mem_dst),
    .mem_data (bus.mem_result),
    .wb_we    (bus.wb_reg_write),
    .wb_dst   (bus.wb_dst),
    .wb_data  (bus.wb_result),
    .fwd_data (rt_fwd)
  );

  // extend in ID so EX sees a full-width immediate with no extra logic
  always_comb begin
    id_ext_imm = {{(DW-IMM_W){bus.id_ext_op & bus.id_imm16[IMM_W-1]}}, bus.id_imm16};
  end

  // next contents: flush beats stall beats load
  always_comb begin
    stage_d = stage_q;
    if (bus.flush) begin
      stage_d = bubble();
    end else if (bus.stall) begin
      // Re-latch the forwarded operands so a result retiring from WB while
      // we wait is kept; without forwarding this is a plain hold.
      stage_d.rs_data = rs_fwd;
      stage_d.rt_data = rt_fwd;
    end else begin
      stage_d.valid     = bus.id_valid;
      stage_d.rs_data   = bus.id_rs_data;
      stage_d.rt_data   = bus.id_rt_data;
      stage_d.rs        = bus.id_rs;
      stage_d.rt        = bus.id_rt;
      stage_d.dst       = bus.id_dst;
      stage_d.ext_imm   = id_ext_imm;
      stage_d.alu_src   = bus.id_alu_src;
      stage_d.alu_ctr   = bus.id_alu_ctr;
      stage_d.reg_write = bus.id_reg_write & bus.id_valid;
    end
  end

  // stage register; reset drops straight to a bubble without a clock
  always_ff @(posedge clk or posedge rst) begin
    if (rst) stage_q <= bubble();
    else     stage_q <= stage_d;
  end

  // EX outputs: B takes the immediate when selected, store data is always rt
  always_comb begin
    bus.ex_a          = rs_fwd;
    bus.ex_b          = stage_q.alu_src ? stage_q.ext_imm : rt_fwd;
    bus.ex_alu_ctr    = stage_q.alu_ctr;
    bus.ex_store_data = rt_fwd;
    bus.ex_dst        = stage_q.dst;
    bus.ex_reg_write  = stage_q.reg_write & stage_q.valid;
    bus.ex_valid      = stage_q.valid;
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: directed scoreboard bench for id_ex_stage. Stimulus pushes
// hand-computed expectations; a negedge monitor pops one per cycle and checks.
module tb_id_ex_stage;
  import id_ex_stage_pkg::*;

`ifdef ID_EX_FORWARD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic clk;
  logic rst;

  id_ex_stage_if #(.DW(32), .RW(5)) bus ();

  id_ex_stage #(.DW(32), .RW(5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  ctr;
    logic        v;
    logic        rw;
    logic [31:0] sd;
    logic [4:0]  dst;
  } exp_t;

  exp_t exp_q[$];
  exp_t cur;
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic chk(input string nm, input string fld,
                     input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s.%s actual=%h required=%h", nm, fld, act, req);
    end
  endtask

  // monitor: one expectation per cycle, checked away from the active edge
  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      cur = exp_q.pop_front();
      chk(cur.name, "ex_a",          bus.ex_a,                 cur.a);
      chk(cur.name, "ex_b",          bus.ex_b,                 cur.b);
      chk(cur.name, "ex_alu_ctr",    32'(bus.ex_alu_ctr),      32'(cur.ctr));
      chk(cur.name, "ex_valid",      32'(bus.ex_valid),        32'(cur.v));
      chk(cur.name, "ex_reg_write",  32'(bus.ex_reg_write),    32'(cur.rw));
      chk(cur.name, "ex_store_data", bus.ex_store_data,        cur.sd);
      chk(cur.name, "ex_dst",        32'(bus.ex_dst),          32'(cur.dst));
    end
  end

  task automatic push_exp(input string nm, input logic [31:0] a, input logic [31:0] b,
                          input logic [3:0] ctr, input logic v, input logic rw,
                          input logic [31:0] sd, input logic [4:0] dst);
    exp_t e;
    e.name = nm; e.a = a; e.b = b; e.ctr = ctr; e.v = v; e.rw = rw; e.sd = sd; e.dst = dst;
    exp_q.push_back(e);
  endtask

  task automatic load(input logic v, input logic [4:0] rs, input logic [31:0] rsd,
                      input logic [4:0] rt, input logic [31:0] rtd, input logic [4:0] dst,
                      input logic [15:0] imm, input logic ext, input logic src,
                      input logic [3:0] ctr, input logic rw);
    bus.id_valid = v;   bus.id_rs = rs;     bus.id_rs_data = rsd;
    bus.id_rt = rt;     bus.id_rt_data = rtd; bus.id_dst = dst;
    bus.id_imm16 = imm; bus.id_ext_op = ext; bus.id_alu_src = src;
    bus.id_alu_ctr = ctr; bus.id_reg_write = rw;
  endtask

  task automatic fwd(input logic mwe, input logic [4:0] mdst, input logic [31:0] mres,
                     input logic wwe, input logic [4:0] wdst, input logic [31:0] wres);
    bus.mem_reg_write = mwe; bus.mem_dst = mdst; bus.mem_result = mres;
    bus.wb_reg_write  = wwe; bus.wb_dst  = wdst; bus.wb_result  = wres;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    bus.stall = 1'b0;
    bus.flush = 1'b0;
    load(1'b0, 5'd0, 32'h0, 5'd0, 32'h0, 5'd0, 16'h0, 1'b0, 1'b0, ALU_ADDU, 1'b0);
    fwd(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    push_exp("reset_state", 32'h0, 32'h0, 4'h1, 1'b0, 1'b0, 32'h0, 5'd0);
    rst = 1'b0;

    // immediate extension
    load(1'b1, 5'd1, 32'd5, 5'd2, 32'd9, 5'd4, 16'h8000, 1'b1, 1'b1, ALU_ADD, 1'b1);
    step();
    push_exp("sext", 32'd5, 32'hFFFF8000, 4'h0, 1'b1, 1'b1, 32'd9, 5'd4);
    load(1'b1, 5'd1, 32'd5, 5'd2, 32'd9, 5'd4, 16'h8000, 1'b0, 1'b1, ALU_ADD, 1'b1);
    step();
    push_exp("zext", 32'd5, 32'h00008000, 4'h0, 1'b1, 1'b1, 32'd9, 5'd4);

    // forward priority MEM over WB, then WB alone
    load(1'b1, 5'd3, 32'h1, 5'd0, 32'h10, 5'd5, 16'h0, 1'b0, 1'b0, ALU_SUB, 1'b1);
    step();
    fwd(1'b1, 5'd3, 32'hAA, 1'b1, 5'd3, 32'hBB);
    push_exp("fwd_mem_over_wb", FWD ? 32'hAA : 32'h1, 32'h10, 4'h2, 1'b1, 1'b1, 32'h10, 5'd5);
    step();
    fwd(1'b0, 5'd3, 32'hAA, 1'b1, 5'd3, 32'hBB);
    push_exp("fwd_wb", FWD ? 32'hBB : 32'h1, 32'h10, 4'h2, 1'b1, 1'b1, 32'h10, 5'd5);

    // immediate on B while store data still follows forwarded rt
    fwd(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    load(1'b1, 5'd6, 32'h20, 5'd6, 32'h30, 5'd10, 16'h0004, 1'b1, 1'b1, ALU_OR, 1'b1);
    step();
    fwd(1'b1, 5'd6, 32'hCC, 1'b0, 5'd0, 32'h0);
    push_exp("fwd_store_imm", FWD ? 32'hCC : 32'h20, 32'h4, 4'h5, 1'b1, 1'b1,
             FWD ? 32'hCC : 32'h30, 5'd10);

    // register zero never forwards
    fwd(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    load(1'b1, 5'd0, 32'h77, 5'd0, 32'h66, 5'd11, 16'h0, 1'b0, 1'b0, ALU_AND, 1'b1);
    step();
    fwd(1'b1, 5'd0, 32'h1234, 1'b1, 5'd0, 32'h5678);
    push_exp("reg_zero", 32'h77, 32'h66, 4'h4, 1'b1, 1'b1, 32'h66, 5'd11);

    // invalid instruction never writes back
    fwd(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    load(1'b0, 5'd1, 32'h3, 5'd2, 32'h4, 5'd12, 16'h0, 1'b0, 1'b0, ALU_SUBU, 1'b1);
    step();
    push_exp("invalid_no_write", 32'h3, 32'h4, 4'h3, 1'b0, 1'b0, 32'h4, 5'd12);

    // stall capture of a WB result retiring during the stall
    load(1'b1, 5'd1, 32'h2, 5'd7, 32'h0, 5'd9, 16'h0, 1'b0, 1'b0, ALU_XOR, 1'b1);
    step();
    bus.stall = 1'b1;
    load(1'b1, 5'd3, 32'h88, 5'd3, 32'h99, 5'd13, 16'h0, 1'b0, 1'b0, ALU_NOR, 1'b1);
    fwd(1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 32'h55);
    push_exp("stall_wb_live", 32'h2, FWD ? 32'h55 : 32'h0, 4'h6, 1'b1, 1'b1,
             FWD ? 32'h55 : 32'h0, 5'd9);
    step();
    fwd(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    push_exp("stall_capture", 32'h2, FWD ? 32'h55 : 32'h0, 4'h6, 1'b1, 1'b1,
             FWD ? 32'h55 : 32'h0, 5'd9);
    step();
    bus.stall = 1'b0;
    push_exp("stall_hold", 32'h2, FWD ? 32'h55 : 32'h0, 4'h6, 1'b1, 1'b1,
             FWD ? 32'h55 : 32'h0, 5'd9);
    step();
    push_exp("after_stall", 32'h88, 32'h99, 4'h7, 1'b1, 1'b1, 32'h99, 5'd13);

    // flush wins over stall
    load(1'b1, 5'd2, 32'h11, 5'd3, 32'h22, 5'd8, 16'h0, 1'b0, 1'b0, ALU_ADD, 1'b1);
    step();
    push_exp("flush_pre", 32'h11, 32'h22, 4'h0, 1'b1, 1'b1, 32'h22, 5'd8);
    bus.flush = 1'b1;
    bus.stall = 1'b1;
    step();
    bus.flush = 1'b0;
    bus.stall = 1'b0;
    push_exp("flush_stall", 32'h0, 32'h0, 4'h1, 1'b0, 1'b0, 32'h0, 5'd0);

    // asynchronous reset in mid-cycle
    load(1'b1, 5'd1, 32'h42, 5'd2, 32'h43, 5'd14, 16'h0, 1'b0, 1'b0, ALU_SLT, 1'b1);
    step();
    push_exp("pre_reset", 32'h42, 32'h43, 4'hA, 1'b1, 1'b1, 32'h43, 5'd14);
    step();
    #2;
    rst = 1'b1;
    push_exp("async_reset", 32'h0, 32'h0, 4'h1, 1'b0, 1'b0, 32'h0, 5'd0);
    step();
    rst = 1'b0;

    // drain the scoreboard with a bounded wait
    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(posedge clk);
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain pending=%0d required=0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
